// File: rtl/sync_counter.sv
// sync_counter: up/down modulo counter with clear, clamped load,
// combinational terminal count and sticky wrap flag.
module sync_counter #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrapped
);
   logic             at_max, at_zero, wrap_evt;
   logic [WIDTH-1:0] load_clamped, step;
   always_comb begin
      at_max       = count == MAX_VAL;
      at_zero      = count == '0;
      wrap_evt     = up_dn ? at_max : at_zero;
      load_clamped = load_val > MAX_VAL ? MAX_VAL : load_val;
      step         = up_dn ? (at_max ? '0 : count + WIDTH'(1))
                           : (at_zero ? MAX_VAL : count - WIDTH'(1));
      // count is 0 during reset, so a down-enabled counter must be masked
      tc           = ~rst & en & wrap_evt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         wrapped <= 1'b0;
      end else if (clr) begin
         count   <= '0;
         wrapped <= 1'b0;
      end else if (load) begin
         count   <= load_clamped;
      end else if (en) begin
         count   <= step;
         if (wrap_evt) wrapped <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sync_counter.sv
// tb_sync_counter: directed tests on a full-range (15) and a modulo-10 (9) counter.
module tb_sync_counter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] count_a, count_b;
   logic       tc_a, tc_b, wrapped_a, wrapped_b;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   sync_counter #(.WIDTH(4), .MAX_VAL(4'd15)) u_a (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .count(count_a), .tc(tc_a), .wrapped(wrapped_a));

   sync_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_b (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .count(count_b), .tc(tc_b), .wrapped(wrapped_b));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      en = 1'b1;
      up_dn = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (count_a !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_a); end
         total++;
         if (wrapped_a !== 1'b0) begin bad++; $display("FAIL reset_wrapped got=%b exp=0", wrapped_a); end
         total++;
         if (tc_a !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b exp=0", tc_a); end
         if (k == 0) step();
      end
      en = 1'b0;
      #6;
      rst = 1'b0;
      step();
      total++;
      if (count_a !== 4'd0) begin bad++; $display("FAIL post_reset_count got=%0d exp=0", count_a); end
   endtask

   task automatic test_up_wrap();
      en = 1'b1;
      up_dn = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         total++;
         if (count_a !== 4'(i % 16)) begin bad++; $display("FAIL up_count i=%0d got=%0d exp=%0d", i, count_a, i % 16); end
         total++;
         if (tc_a !== ((i % 16) == 15)) begin bad++; $display("FAIL up_tc i=%0d got=%b exp=%b", i, tc_a, (i % 16) == 15); end
         total++;
         if (wrapped_a !== (i >= 16)) begin bad++; $display("FAIL up_wrapped i=%0d got=%b exp=%b", i, wrapped_a, i >= 16); end
      end
   endtask

   task automatic test_hold();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (count_a !== 4'd4) begin bad++; $display("FAIL hold_count got=%0d exp=4", count_a); end
         total++;
         if (wrapped_a !== 1'b1) begin bad++; $display("FAIL hold_wrapped got=%b exp=1", wrapped_a); end
         total++;
         if (tc_a !== 1'b0) begin bad++; $display("FAIL hold_tc got=%b exp=0", tc_a); end
      end
   endtask

   task automatic test_down_modulus();
      logic [3:0] exp_c [3] = '{4'd0, 4'd9, 4'd8};
      logic       exp_t [3] = '{1'b1, 1'b0, 1'b0};
      logic       exp_w [3] = '{1'b0, 1'b1, 1'b1};
      clr = 1'b1;
      step();
      clr = 1'b0;
      total++;
      if (count_b !== 4'd0 || wrapped_b !== 1'b0) begin bad++; $display("FAIL clr_b got=%0d/%b exp=0/0", count_b, wrapped_b); end
      load = 1'b1;
      load_val = 4'd1;
      step();
      load = 1'b0;
      en = 1'b1;
      up_dn = 1'b0;
      #1;
      total++;
      if (count_b !== 4'd1 || tc_b !== 1'b0) begin bad++; $display("FAIL load1_b got=%0d/%b exp=1/0", count_b, tc_b); end
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (count_b !== exp_c[i]) begin bad++; $display("FAIL down_count i=%0d got=%0d exp=%0d", i, count_b, exp_c[i]); end
         total++;
         if (tc_b !== exp_t[i]) begin bad++; $display("FAIL down_tc i=%0d got=%b exp=%b", i, tc_b, exp_t[i]); end
         total++;
         if (wrapped_b !== exp_w[i]) begin bad++; $display("FAIL down_wrapped i=%0d got=%b exp=%b", i, wrapped_b, exp_w[i]); end
      end
   endtask

   task automatic test_load_priority();
      en = 1'b0;
      up_dn = 1'b1;
      load = 1'b1;
      load_val = 4'd12;
      step();
      total++;
      if (count_b !== 4'd9) begin bad++; $display("FAIL load_clamp got=%0d exp=9", count_b); end
      total++;
      if (wrapped_b !== 1'b1) begin bad++; $display("FAIL load_keeps_wrapped got=%b exp=1", wrapped_b); end
      total++;
      if (count_a !== 4'd12) begin bad++; $display("FAIL load_unclamped got=%0d exp=12", count_a); end
      clr = 1'b1;
      en = 1'b1;
      step();
      total++;
      if (count_b !== 4'd0 || wrapped_b !== 1'b0) begin bad++; $display("FAIL clr_priority got=%0d/%b exp=0/0", count_b, wrapped_b); end
      clr = 1'b0;
      load = 1'b0;
      en = 1'b0;
   endtask

   task automatic test_async_reset();
      load = 1'b1;
      load_val = 4'd7;
      step();
      load = 1'b0;
      en = 1'b1;
      up_dn = 1'b1;
      total++;
      if (count_a !== 4'd7) begin bad++; $display("FAIL pre_rst_count got=%0d exp=7", count_a); end
      #3;
      rst = 1'b1;
      #1;
      total++;
      if (count_a !== 4'd0) begin bad++; $display("FAIL async_rst_count got=%0d exp=0", count_a); end
      total++;
      if (wrapped_a !== 1'b0 || tc_a !== 1'b0) begin bad++; $display("FAIL async_rst_flags got=%b/%b exp=0/0", wrapped_a, tc_a); end
      #1;
      rst = 1'b0;
      step();
      total++;
      if (count_a !== 4'd1) begin bad++; $display("FAIL post_async_count got=%0d exp=1", count_a); end
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_hold();
      test_down_modulus();
      test_load_priority();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
